// File: rtl/trivium_par.sv
// trivium_par: Trivium keystream generator producing W bits per clock, with an
// automatic key/IV warm-up and a valid/ready keystream output.
module trivium_par #(
  parameter int unsigned W      = 8,
  parameter int unsigned WARMUP = 1152
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  output logic         busy,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [W-1:0] ks_data
);

  localparam int unsigned S_W      = 288;
  localparam int unsigned WARM_CYC = WARMUP / W;
  localparam int unsigned CNT_W    = $clog2(WARM_CYC + 1);

  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
    $error("trivium_par: W must be one of 1, 2, 4, 8, 16, 32, 64");
  end
  if (WARMUP == 0 || (WARMUP % W) != 0) begin : g_bad_warmup
    $error("trivium_par: WARMUP must be a non-zero multiple of W");
  end

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [S_W-1:0]   s_q, s_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [S_W-1:0]   s_adv_c;
  logic [S_W-1:0]   s_load_c;
  logic [W-1:0]     z_c;

  // Bit k-1 of the state vector holds Trivium state bit s[k].
  assign s_load_c = {3'b111, 108'b0, 4'b0, iv, 13'b0, key};

  // W chained rounds; round j's output bit lands at position W-1-j.
  always_comb begin : p_rounds
    logic [S_W-1:0] s;
    logic           t1, t2, t3;
    z_c = '0;
    s   = s_q;
    t1  = 1'b0;
    t2  = 1'b0;
    t3  = 1'b0;
    for (int j = 0; j < W; j++) begin
      t1 = s[65] ^ s[92];
      t2 = s[161] ^ s[176];
      t3 = s[242] ^ s[287];
      z_c[W-1-j] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[90] & s[91]) ^ s[170];
      t2 = t2 ^ (s[174] & s[175]) ^ s[263];
      t3 = t3 ^ (s[285] & s[286]) ^ s[68];
      s  = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
    s_adv_c = s;
  end

  // Next-state: warm-up advances every cycle, run advances on handshake, init overrides.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    case (state_q)
      WARM: begin
        s_d   = s_adv_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WARM_CYC - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (valid_q && ks_ready) begin
          s_d = s_adv_c;
        end
      end
      default: ;
    endcase
    if (init) begin
      s_d     = s_load_c;
      cnt_d   = '0;
      state_d = WARM;
    end
    busy_d  = (state_d == WARM);
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy     = busy_q;
  assign ks_valid = valid_q;
  assign ks_data  = z_c;

endmodule

// File: tb/tb_trivium_par.sv
// Self-checking bench for trivium_par: bit-array Trivium model, table-driven
// key/iv runs with random backpressure, width equivalence, re-init and async reset.
module tb_trivium_par;

  localparam int unsigned WM   = 8;
  localparam int unsigned WU   = 1152;
  localparam int unsigned WCYC = WU / WM;
  localparam int unsigned NBIT = 4096;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic        init_x;
  logic        ks_ready;
  logic [79:0] key;
  logic [79:0] iv;
  logic        busy, ks_valid;
  logic [7:0]  ks_data;
  logic        busy1, valid1;
  logic [0:0]  data1;
  logic        busy64, valid64;
  logic [63:0] data64;

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  trivium_par #(.W(8), .WARMUP(1152)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .key(key), .iv(iv),
    .busy(busy), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data)
  );

  trivium_par #(.W(1), .WARMUP(1152)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .init(init_x), .key(key), .iv(iv),
    .busy(busy1), .ks_valid(valid1), .ks_ready(1'b1), .ks_data(data1)
  );

  trivium_par #(.W(64), .WARMUP(1152)) dut_w64 (
    .clk(clk), .rst_n(rst_n), .init(init_x), .key(key), .iv(iv),
    .busy(busy64), .ks_valid(valid64), .ks_ready(1'b1), .ks_data(data64)
  );

  // ---------------- reference model: s[1..288] as a plain bit array
  bit          ms [1:288];
  logic [63:0] cur_exp;

  task automatic m_load(input logic [79:0] k, input logic [79:0] v);
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = k[i-1];
      ms[93 + i] = v[i-1];
    end
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
  endtask

  task automatic m_round(output bit z);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
    ms[178] = t2;
    for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
    ms[94] = t1;
    for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
    ms[1] = t3;
  endtask

  task automatic m_word(input int w, output logic [63:0] word);
    bit z;
    word = '0;
    for (int j = 0; j < w; j++) begin
      m_round(z);
      word = {word[62:0], z};
    end
  endtask

  task automatic m_warm();
    bit z;
    for (int i = 0; i < int'(WU); i++) m_round(z);
  endtask

  // ---------------- helpers
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] rnd80();
    return 80'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Pulse init for one cycle; key/iv are scrambled afterwards and must be ignored.
  task automatic do_init(input logic [79:0] k, input logic [79:0] v);
    key  = k;
    iv   = v;
    init = 1'b1;
    tick();
    init = 1'b0;
    key  = rnd80();
    iv   = rnd80();
    m_load(k, v);
    m_warm();
    m_word(WM, cur_exp);
  endtask

  // Called on cycle 1 after the init edge; returns on the first RUN cycle.
  task automatic warm_check(input string name);
    for (int c = 1; c <= int'(WCYC); c++) begin
      check({name, "_warm"}, 64'({busy, ks_valid}), 64'b10);
      tick();
    end
    check({name, "_run"}, 64'({busy, ks_valid}), 64'b01);
  endtask

  // Accept nacc words with ks_ready at duty% and compare every cycle's word.
  task automatic run_stream(input string name, input int nacc, input int duty);
    logic [7:0] held;
    bit         have_held;
    int         acc;
    int         cyc;
    have_held = 1'b0;
    acc       = 0;
    cyc       = 0;
    held      = '0;
    while (acc < nacc && cyc < nacc * 50 + 100) begin
      check({name, "_valid"}, 64'(ks_valid), 64'd1);
      check({name, "_data"}, 64'(ks_data), cur_exp);
      if (have_held) check({name, "_hold"}, 64'(ks_data), 64'(held));
      ks_ready = ($urandom_range(0, 99) < duty);
      if (ks_ready) begin
        acc++;
        have_held = 1'b0;
        m_word(WM, cur_exp);
      end else begin
        have_held = 1'b1;
        held      = ks_data;
      end
      tick();
      cyc++;
    end
    ks_ready = 1'b0;
    check({name, "_accepted"}, 64'(acc), 64'(nacc));
  endtask

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    int          duty;
    int          nacc;
    logic [63:0] exp_first;
  } vec_t;

  localparam logic [79:0] SPEC_KEY = 80'h9719CFC92A9FF688F9AA;
  localparam logic [79:0] SPEC_IV  = 80'hECBB76B09AFF71D0D151;

  vec_t tbl [6];
  bit   ref_bits [NBIT];

  initial begin
    logic [63:0] w;
    bit          z;
    int          i1, i8, i64, cyc;

    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    init     = 1'b0;
    init_x   = 1'b0;
    ks_ready = 1'b0;
    key      = '0;
    iv       = '0;

    // Reset and idle
    #3;
    check("reset_out", 64'({busy, ks_valid, ks_data}), 64'd0);
    #20;
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      check("idle_out", 64'({busy, ks_valid, ks_data}), 64'd0);
    end

    // Table of key/iv runs; expected first words come from the model
    tbl[0] = '{SPEC_KEY, SPEC_IV, 100, 20, '0};
    tbl[1] = '{80'h0, 80'h0, 30, 20, '0};
    tbl[2] = '{{80{1'b1}}, {80{1'b1}}, 70, 20, '0};
    for (int t = 3; t < 6; t++) tbl[t] = '{rnd80(), rnd80(), 20 + int'($urandom_range(0, 70)), 16, '0};
    for (int t = 0; t < 6; t++) begin
      m_load(tbl[t].key, tbl[t].iv);
      m_warm();
      m_word(WM, tbl[t].exp_first);
    end
    for (int t = 0; t < 6; t++) begin
      do_init(tbl[t].key, tbl[t].iv);
      warm_check($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_first", t), 64'(ks_data), tbl[t].exp_first);
      run_stream($sformatf("tbl%0d", t), tbl[t].nacc, tbl[t].duty);
    end

    // Width equivalence: W=1, 8, 64 against one 4096-bit model stream
    m_load(SPEC_KEY, SPEC_IV);
    m_warm();
    for (int i = 0; i < int'(NBIT); i++) begin
      m_round(z);
      ref_bits[i] = z;
    end
    key      = SPEC_KEY;
    iv       = SPEC_IV;
    init     = 1'b1;
    init_x   = 1'b1;
    ks_ready = 1'b1;
    tick();
    init   = 1'b0;
    init_x = 1'b0;
    key    = rnd80();
    iv     = rnd80();
    check("eq_busy", 64'({busy1, busy64, busy}), 64'b111);
    i1  = 0;
    i8  = 0;
    i64 = 0;
    cyc = 0;
    while ((i1 < int'(NBIT) || i8 < int'(NBIT) || i64 < int'(NBIT)) && cyc < int'(WU + NBIT) + 100) begin
      if (valid1 && i1 < int'(NBIT)) begin
        check($sformatf("eq_w1_bit%0d", i1), 64'(data1), 64'(ref_bits[i1]));
        i1++;
      end
      if (ks_valid && i8 < int'(NBIT)) begin
        w = '0;
        for (int b = 0; b < 8; b++) w = {w[62:0], ref_bits[i8 + b]};
        check($sformatf("eq_w8_bit%0d", i8), 64'(ks_data), w);
        i8 += 8;
      end
      if (valid64 && i64 < int'(NBIT)) begin
        w = '0;
        for (int b = 0; b < 64; b++) w = {w[62:0], ref_bits[i64 + b]};
        check($sformatf("eq_w64_bit%0d", i64), data64, w);
        i64 += 64;
      end
      tick();
      cyc++;
    end
    ks_ready = 1'b0;
    check("eq_done", 64'({i1[15:0], i8[15:0], i64[15:0]}),
          64'({16'(NBIT), 16'(NBIT), 16'(NBIT)}));

    // Re-init mid-run, with a handshake in the init cycle
    do_init(SPEC_KEY, SPEC_IV);
    warm_check("reinit_a");
    run_stream("reinit_a", 10, 100);
    check("reinit_hs_data", 64'(ks_data), cur_exp);
    ks_ready = 1'b1;
    do_init(SPEC_KEY, 80'h0123456789ABCDEF0F1E);
    ks_ready = 1'b0;
    check("reinit_drop", 64'({busy, ks_valid}), 64'b10);
    warm_check("reinit_b");
    run_stream("reinit_b", 20, 40);

    // Asynchronous reset at warm-up cycle 70, between clock edges
    do_init(rnd80(), rnd80());
    for (int c = 1; c < 70; c++) tick();
    check("areset_pre", 64'({busy, ks_valid}), 64'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out", 64'({busy, ks_valid, ks_data}), 64'd0);
    tick();
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("areset_idle", 64'({busy, ks_valid, ks_data}), 64'd0);
    end
    do_init(SPEC_KEY, 80'hA5A5_5A5A_0000_FFFF_1234);
    warm_check("areset_restart");
    run_stream("areset_restart", 30, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trivium_par.md
Name: trivium_par

Overview:
- Parametrised Trivium keystream generator; successor to the single-bit `trivium` core.
- Produces W keystream bits per clock, via W unrolled state updates per cycle.
- Runs the key/IV warm-up automatically after a one-cycle init pulse.
- Delivers keystream words over a valid/ready stream, so downstream XOR/serialiser logic can stall it without losing bits.

Parameters:
- W, 8, keystream bits per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64. Any other value is an elaboration error.
- WARMUP, 1152, warm-up state updates before output. Must be a multiple of W, else elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- init  input  1  single-cycle pulse: load key/iv and start warm-up.
- key  input  80  cipher key, sampled only in the cycle init=1.
- iv  input  80  initialisation vector, sampled only in the cycle init=1.
- busy  output  1  high while in warm-up.
- ks_valid  output  1  ks_data holds a valid keystream word.
- ks_ready  input  1  consumer accepts the word this cycle.
- ks_data  output  W  keystream word; bit W-1 is the earliest bit in time (MSB-first).

Behaviour:
- State: 288-bit register s[1..288], a warm-up counter of width clog2(WARMUP/W+1), FSM {IDLE, WARM, RUN}.
- Reset (rst_n=0, asynchronous): s=0, counter=0, FSM=IDLE, busy=0, ks_valid=0, ks_data=0.
- Load mapping on an init=1 cycle (any state):
  - s[i]=key[i-1] for i=1..80; s[81..93]=0.
  - s[93+i]=iv[i-1] for i=1..80; s[174..177]=0.
  - s[178..285]=0; s[286..288]=1.
  - counter=0; FSM goes to WARM on the next edge.
- Standard Trivium round:
  - t1=s66^s93, t2=s162^s177, t3=s243^s288.
  - z=t1^t2^t3.
  - t1'=t1^(s91&s92)^s171, t2'=t2^(s175&s176)^s264, t3'=t3^(s286&s287)^s69.
  - Shift: s[1..93]<={t3',s1..s92}, s[94..177]<={t1',s94..s176}, s[178..288]<={t2',s178..s287}.
- One advance = W chained rounds in one cycle. ks_data[W-1-j] = z of round j, j=0..W-1.
- ks_data is combinational from the current s.
- IDLE: ks_valid=0, busy=0, s holds.
- WARM:
  - busy=1, ks_valid=0.
  - Advance every cycle; counter increments.
  - When counter reaches WARMUP/W-1 and advances, FSM goes to RUN.
  - Total time is WARMUP/W cycles, e.g. 144 for W=8.
- RUN:
  - busy=0, ks_valid=1.
  - Advance only on ks_valid&ks_ready.
  - With ks_ready=0, s and ks_data are held bit-stable indefinitely.
- init during WARM or RUN: reload and restart warm-up.
  - ks_valid=0 from the next cycle.
  - A word handshaken in the same cycle as init counts as delivered.
  - init has priority over advance.
- key/iv changes outside init cycles have no effect.
- Reset asserted mid-warm-up or mid-run: immediate return to reset values. init is required to restart.
- No rekey limit; RUN continues until init or reset.
- Latency: first valid word appears WARMUP/W+1 cycles after the init edge (init cycle + warm-up).

Test Plan:
- Reset/idle: rst_n=0 then 1, no init, 50 cycles -> busy=0, ks_valid=0, ks_data=0 throughout.
- Warm-up timing, W=8, WARMUP=1152: init pulse at cycle 0 -> busy=1 on cycles 1..144; ks_valid=1 from cycle 145; busy=0 from 145.
- Width equivalence, key=80'h9719CFC92A9FF688F9AA, iv=80'hECBB76B09AFF71D0D151, ks_ready=1:
  - Instances W=1, 8, 64 must produce an identical MSB-first bitstream for the first 4096 bits.
  - The W=1 stream also equals the `trivium` core's output for the same key/iv.
- Backpressure: W=8 in RUN, random ks_ready at 30% duty -> ks_data stable while ks_ready=0; concatenated accepted words equal the ks_ready=1 stream bit-for-bit.
- Re-init mid-run: after 10 accepted words, pulse init with a new iv -> ks_valid=0 next cycle; after 144 more cycles the stream equals a fresh run for the new iv.
- Async reset mid-warm-up: drop rst_n at cycle 70 of warm-up, between clock edges -> outputs go to reset values without waiting for a clock edge; init after release gives normal 144-cycle warm-up and matching stream.
